// File: rtl/pipe_mux_n_pkg.sv
// Shared pipeline-select definitions. The hazard unit and the operand mux both
// import these constants, so they always agree on the forwarding-source indices.
package pipe_mux_n_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_NUM_IN = 4;
  localparam int DEFAULT_SEL_W  = 2;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_src_e;

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry valid/ready register slice with flush. in_ready depends only on
// registered state, so the upstream never sees a combinational path from out_ready.
module pipe_skid_reg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              main_valid_q, main_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic              accept;

  assign in_ready = !rst && !skid_valid_q;
  assign accept   = in_valid && in_ready;

  always_comb begin
    // NOTE: every next-state signal gets a default first, otherwise any path
    // that skips an assignment infers a latch.
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;

    if (!main_valid_q || out_ready) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = in_data;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_data;
      skid_valid_d = 1'b1;
    end

    // Flush beats accept: drop everything, leave the data registers untouched.
    if (flush) begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  // NOTE: the data registers are reset too, so out_data reads 0 after reset
  // rather than whatever the flops powered up with.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples the pre-edge values regardless of statement order.
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_data  = main_q;
  assign out_valid = main_valid_q;

endmodule

// File: rtl/pipe_mux_n.sv
// N-way operand select feeding a stallable, flushable skid register.
// An out-of-range select captures 0 and sets a sticky error that only rst clears.
module pipe_mux_n
  import pipe_mux_n_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int NUM_IN = DEFAULT_NUM_IN,
  parameter int SEL_W  = DEFAULT_SEL_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NUM_IN*DATA_W-1:0] data_in,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sel_err
);

  if (NUM_IN < 2 || SEL_W != $clog2(NUM_IN)) begin : g_bad_param
    $error("pipe_mux_n: need NUM_IN >= 2 and SEL_W == $clog2(NUM_IN)");
  end

  logic [DATA_W-1:0] word;
  logic              sel_ok;
  logic              accept;
  logic              sel_err_q, sel_err_d;

  always_comb begin
    word   = '0;
    sel_ok = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        word   = data_in[i*DATA_W +: DATA_W];
        sel_ok = 1'b1;
      end
    end
  end

  assign accept = in_valid && in_ready;

  // A bad select is recorded even when a same-cycle flush discards the word.
  assign sel_err_d = sel_err_q || (accept && !sel_ok);

  always_ff @(posedge clk) begin
    if (rst) sel_err_q <= 1'b0;
    else     sel_err_q <= sel_err_d;
  end

  assign sel_err = sel_err_q;

  pipe_skid_reg #(.DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (word),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

endmodule

// File: tb/tb_pipe_mux_n.sv
// Directed checks of pipe_mux_n (4-input and 3-input builds) plus a scoreboarded
// stall/flush sweep on the 4-input build.
module tb_pipe_mux_n;
  import pipe_mux_n_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, in_valid, out_ready;
  logic [31:0] data_in;
  logic [1:0]  sel;
  logic        in_ready, out_valid, sel_err;
  logic [7:0]  out_data;

  logic        flush3, in_valid3, out_ready3;
  logic [23:0] data_in3;
  logic [1:0]  sel3;
  logic        in_ready3, out_valid3, sel_err3;
  logic [7:0]  out_data3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_mux_n #(.DATA_W(8), .NUM_IN(4), .SEL_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .data_in(data_in), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err)
  );

  pipe_mux_n #(.DATA_W(8), .NUM_IN(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst(rst), .flush(flush3), .data_in(data_in3), .sel(sel3),
    .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
    .out_valid(out_valid3), .out_ready(out_ready3), .sel_err(sel_err3)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] w;
  logic       rv, rr, rf, acc, fire;
  logic [1:0] rs;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    data_in = '0; sel = '0;
    flush3 = 1'b0; in_valid3 = 1'b0; out_ready3 = 1'b0; data_in3 = '0; sel3 = '0;

    // Reset
    tick();
    check("rst_in_ready", in_ready, 0);
    tick();
    check("rst_in_ready2", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sel_err", sel_err, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Streaming, one word per cycle
    data_in = {8'h44, 8'h33, 8'h22, 8'h11};
    out_ready = 1'b1;
    in_valid = 1'b1; sel = FWD_RF;
    tick(); check("stream_v0", out_valid, 1); check("stream_d0", out_data, 8'h11);
    sel = FWD_EX;
    tick(); check("stream_v1", out_valid, 1); check("stream_d1", out_data, 8'h22);
    sel = FWD_MEM;
    tick(); check("stream_v2", out_valid, 1); check("stream_d2", out_data, 8'h33);
    sel = FWD_WB;
    tick(); check("stream_v3", out_valid, 1); check("stream_d3", out_data, 8'h44);
    in_valid = 1'b0;
    tick(); check("stream_drain", out_valid, 0);

    // Backpressure into the skid entry
    data_in = {8'h77, 8'h66, 8'hB2, 8'hA1};
    out_ready = 1'b0;
    in_valid = 1'b1; sel = 2'd0;
    tick(); check("bp_v_a1", out_valid, 1); check("bp_d_a1", out_data, 8'hA1);
    check("bp_rdy_after1", in_ready, 1);
    sel = 2'd1;
    tick(); check("bp_rdy_after2", in_ready, 0); check("bp_hold_d", out_data, 8'hA1);
    in_valid = 1'b0;
    tick(); check("bp_stall_v", out_valid, 1); check("bp_stall_d", out_data, 8'hA1);
    out_ready = 1'b1;
    tick(); check("bp_rel_v", out_valid, 1); check("bp_rel_d", out_data, 8'hB2);
    check("bp_rel_rdy", in_ready, 1);
    tick(); check("bp_empty", out_valid, 0);

    // Flush with main and skid both full
    out_ready = 1'b0;
    in_valid = 1'b1; sel = 2'd0;
    tick();
    sel = 2'd1;
    tick(); check("fl_full_rdy", in_ready, 0);
    sel = 2'd2; flush = 1'b1;
    tick(); flush = 1'b0; in_valid = 1'b0;
    check("fl_v", out_valid, 0); check("fl_rdy", in_ready, 1);
    out_ready = 1'b1;
    tick(); check("fl_no_ghost", out_valid, 0);

    // Flush discards a same-cycle accept
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    tick();
    sel = 2'd3; flush = 1'b1;
    tick(); flush = 1'b0; in_valid = 1'b0;
    check("fl_acc_v", out_valid, 0); check("fl_acc_rdy", in_ready, 1);
    out_ready = 1'b1;
    tick(); check("fl_acc_ghost", out_valid, 0);

    // Out-of-range select on the 3-input build
    data_in3 = {8'hCC, 8'hBB, 8'hAA};
    out_ready3 = 1'b1; in_valid3 = 1'b1; sel3 = 2'd0;
    tick(); check("bad_ok_d", out_data3, 8'hAA); check("bad_ok_err", sel_err3, 0);
    sel3 = 2'd3;
    tick(); check("bad_v", out_valid3, 1); check("bad_d", out_data3, 0);
    check("bad_err", sel_err3, 1);
    sel3 = 2'd2;
    tick(); check("bad_next_d", out_data3, 8'hCC); check("bad_sticky", sel_err3, 1);
    in_valid3 = 1'b0; flush3 = 1'b1;
    tick(); flush3 = 1'b0;
    check("bad_flush_v", out_valid3, 0); check("bad_flush_err", sel_err3, 1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    check("bad_rst_err", sel_err3, 0); check("rst_mid_v", out_valid, 0);

    // Bad select inside a flush cycle still raises sel_err
    in_valid3 = 1'b1; sel3 = 2'd3; flush3 = 1'b1;
    tick(); flush3 = 1'b0; in_valid3 = 1'b0;
    check("bad_fl_err", sel_err3, 1); check("bad_fl_v", out_valid3, 0);

    // Scoreboarded sweep of random valid/ready/flush on the 4-input build
    exp_q.delete();
    for (int c = 0; c < 3000; c++) begin
      check("sb_out_valid", out_valid, exp_q.size() != 0);
      check("sb_in_ready", in_ready, exp_q.size() < 2);
      if (exp_q.size() != 0) check("sb_out_data", out_data, exp_q[0]);

      rv = ($urandom_range(99) < 60);
      rr = ($urandom_range(99) < 55);
      rf = ($urandom_range(99) < 3);
      rs = 2'($urandom_range(3));
      data_in  = $urandom;
      in_valid = rv; out_ready = rr; flush = rf; sel = rs;
      w = data_in[rs*8 +: 8];

      acc  = rv && (exp_q.size() < 2);
      fire = rr && (exp_q.size() != 0);
      if (fire) void'(exp_q.pop_front());
      if (rf) exp_q.delete();
      else if (acc) exp_q.push_back(w);
      tick();
    end
    check("sb_no_sel_err", sel_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
